// File: rtl/sprite_layer_renderer.sv
// sprite_layer_renderer
//   Draws one indexed-colour sprite, picked from NUM_FRAMES frames stored back
//   to back in an external ROM, at a programmable screen position. The sprite
//   supports power-of-2 scaling, X/Y mirroring and a transparent colour key.
//   Position, frame, flips and enable are staged inputs. They are copied into
//   shadow registers on frame_start, so changes made mid-frame never tear the
//   picture.
//
// Ports
//   vga_clk, reset_n      pixel clock (rising edge), async active-low reset
//   DrawX, DrawY, blank   current pixel and active-video flag
//   frame_start           one-cycle pulse that loads the shadow registers
//   pos_x, pos_y          staged top-left corner of the sprite
//   frame_sel             staged frame number (clamped to NUM_FRAMES-1)
//   flip_x, flip_y        staged mirroring
//   enable                staged visibility
//   rom_address           combinational texel address into the sprite ROM
//   rom_q                 ROM data, ROM_LATENCY cycles after rom_address
//   pal_red/green/blue    combinational palette lookup of rom_q
//   red, green, blue      registered colour, 0 where the sprite is not drawn
//   opaque                registered, 1 where a sprite pixel is drawn
//
// Latency from DrawX/DrawY/blank to the outputs is ROM_LATENCY+1 cycles,
// for both hit and non-hit pixels.
module sprite_layer_renderer #(
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int NUM_FRAMES  = 8,
    parameter int SCALE_SHIFT = 0,
    parameter int ROM_LATENCY = 1,
    parameter int IDX_W       = 8,
    parameter logic [IDX_W-1:0] TRANSPARENT_IDX = '0,
    parameter int ADDR_W      = $clog2(SPR_W * SPR_H * NUM_FRAMES),
    parameter int FRM_W       = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_start,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [FRM_W-1:0]  frame_sel,
    input  logic              flip_x,
    input  logic              flip_y,
    input  logic              enable,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              opaque
);

    localparam int LX_W   = $clog2(SPR_W);
    localparam int LY_W   = $clog2(SPR_H);
    localparam int TEX    = SPR_W * SPR_H;
    localparam int SPAN_X = SPR_W << SCALE_SHIFT;
    localparam int SPAN_Y = SPR_H << SCALE_SHIFT;

    typedef struct packed {
        logic [9:0]       x;
        logic [9:0]       y;
        logic [FRM_W-1:0] frame;
        logic             flip_x;
        logic             flip_y;
        logic             enable;
    } shadow_t;

    shadow_t          sh;
    logic [FRM_W-1:0] frame_ld;

    // When NUM_FRAMES fills the select field, every code is a valid frame
    // and no clamp is needed.
    if (NUM_FRAMES == (1 << FRM_W)) begin : g_no_clamp
        assign frame_ld = frame_sel;
    end else begin : g_clamp
        assign frame_ld = (frame_sel >= FRM_W'(NUM_FRAMES)) ? FRM_W'(NUM_FRAMES - 1)
                                                            : frame_sel;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            sh <= '0;
        end else if (frame_start) begin
            sh.x      <= pos_x;
            sh.y      <= pos_y;
            sh.frame  <= frame_ld;
            sh.flip_x <= flip_x;
            sh.flip_y <= flip_y;
            sh.enable <= enable;
        end
    end

    // Hit test runs at 11 bits, so a sprite near the right or bottom edge
    // clips instead of wrapping around to X/Y = 0.
    logic [10:0]     dx, dy;
    logic            in_x, in_y, hit;
    logic [LX_W-1:0] lx_raw, lx;
    logic [LY_W-1:0] ly_raw, ly;

    assign dx   = {1'b0, DrawX} - {1'b0, sh.x};
    assign dy   = {1'b0, DrawY} - {1'b0, sh.y};
    assign in_x = (DrawX >= sh.x) && (dx < 11'(SPAN_X));
    assign in_y = (DrawY >= sh.y) && (dy < 11'(SPAN_Y));
    assign hit  = sh.enable & blank & in_x & in_y;

    // Dropping the low SCALE_SHIFT bits turns screen pixels into texels.
    // On a hit, the remaining bits are already below SPR_W/SPR_H.
    assign lx_raw = dx[SCALE_SHIFT +: LX_W];
    assign ly_raw = dy[SCALE_SHIFT +: LY_W];
    assign lx     = sh.flip_x ? (LX_W'(SPR_W - 1) - lx_raw) : lx_raw;
    assign ly     = sh.flip_y ? (LY_W'(SPR_H - 1) - ly_raw) : ly_raw;

    // Off-sprite pixels point at the frame base so the address is deterministic.
    always_comb begin
        rom_address = ADDR_W'(sh.frame) * ADDR_W'(TEX);
        if (hit) begin
            rom_address = rom_address + ADDR_W'(ly) * ADDR_W'(SPR_W) + ADDR_W'(lx);
        end
    end

    // hit travels alongside the ROM read so that vld_pipe[ROM_LATENCY] lines
    // up with rom_q.
    logic [ROM_LATENCY:1] vld_pipe;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= hit;
            for (int i = 2; i <= ROM_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    logic opaque_next;
    assign opaque_next = vld_pipe[ROM_LATENCY] & (rom_q != TRANSPARENT_IDX);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            red    <= '0;
            green  <= '0;
            blue   <= '0;
            opaque <= 1'b0;
        end else begin
            opaque <= opaque_next;
            red    <= opaque_next ? pal_red   : 4'h0;
            green  <= opaque_next ? pal_green : 4'h0;
            blue   <= opaque_next ? pal_blue  : 4'h0;
        end
    end

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Directed bench for sprite_layer_renderer. It uses two instances that share
// stimulus:
//   dut_a is the default build (SCALE_SHIFT 0, 8 frames).
//   dut_b is a scaled build (SCALE_SHIFT 1) with 6 frames, which exercises
//   the frame clamp.
module tb_sprite_layer_renderer;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic        blank = 1'b0, frame_start = 1'b0;
    logic [9:0]  pos_x = '0, pos_y = '0;
    logic [2:0]  frame_sel = '0;
    logic        flip_x = 1'b0, flip_y = 1'b0, enable = 1'b0;
    logic [7:0]  rom_q = '0;
    logic [3:0]  pal_red = '0, pal_green = '0, pal_blue = '0;

    logic [12:0] addr_a, addr_b;
    logic [3:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic        opaque_a, opaque_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 vga_clk = ~vga_clk;

    sprite_layer_renderer dut_a (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y),
        .frame_sel(frame_sel), .flip_x(flip_x), .flip_y(flip_y), .enable(enable),
        .rom_address(addr_a), .rom_q(rom_q), .pal_red(pal_red),
        .pal_green(pal_green), .pal_blue(pal_blue), .red(red_a), .green(green_a),
        .blue(blue_a), .opaque(opaque_a)
    );

    sprite_layer_renderer #(.SCALE_SHIFT(1), .NUM_FRAMES(6)) dut_b (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y),
        .frame_sel(frame_sel), .flip_x(flip_x), .flip_y(flip_y), .enable(enable),
        .rom_address(addr_b), .rom_q(rom_q), .pal_red(pal_red),
        .pal_green(pal_green), .pal_blue(pal_blue), .red(red_b), .green(green_b),
        .blue(blue_b), .opaque(opaque_b)
    );

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic bl,
                       input logic [7:0] q, input logic [11:0] rgb);
        DrawX = x; DrawY = y; blank = bl; rom_q = q;
        {pal_red, pal_green, pal_blue} = rgb;
    endtask

    // Hold one pixel long enough for the outputs to settle.
    task automatic hold(input logic [9:0] x, input logic [9:0] y, input logic [7:0] q,
                        input logic [11:0] rgb);
        pix(x, y, 1'b1, q, rgb);
        repeat (3) tick();
    endtask

    task automatic load_shadow(input logic [9:0] x, input logic [9:0] y,
                               input logic [2:0] f, input logic fx, input logic fy,
                               input logic en);
        pix(10'd0, 10'd0, 1'b0, 8'd0, 12'h000);
        pos_x = x; pos_y = y; frame_sel = f; flip_x = fx; flip_y = fy; enable = en;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int cnt;
        #1 reset_n = 1'b0;
        #2;
        n_checks++;
        if ({opaque_a, red_a, green_a, blue_a} !== 13'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", {opaque_a, red_a, green_a, blue_a});
        end
        repeat (2) tick();
        #2 reset_n = 1'b1;
        // Staged values are visible but never loaded, so nothing may draw.
        pos_x = 0; pos_y = 0; frame_sel = 0; enable = 1'b1;
        cnt = 0;
        for (int y = 0; y < 40; y++) begin
            for (int x = 0; x < 40; x++) begin
                pix(10'(x), 10'(y), 1'b1, 8'd5, 12'hF81);
                tick();
                if (opaque_a | opaque_b) cnt++;
            end
        end
        n_checks++;
        if (cnt != 0) begin
            n_fail++; $display("FAIL reset_no_shadow_load: got %0d opaque pixels want 0", cnt);
        end
    endtask

    task automatic test_basic_hit();
        load_shadow(10'd100, 10'd50, 3'd2, 1'b0, 1'b0, 1'b1);
        pix(10'd0, 10'd0, 1'b0, 8'd0, 12'h000);
        repeat (3) tick();
        pix(10'd100, 10'd50, 1'b1, 8'd0, 12'h000);
        #1;
        n_checks++;
        if (addr_a !== 13'd2048) begin
            n_fail++; $display("FAIL basic_addr_corner: got %0d want 2048", addr_a);
        end
        tick();
        n_checks++;
        if (opaque_a !== 1'b0) begin
            n_fail++; $display("FAIL basic_latency_early: got %b want 0", opaque_a);
        end
        // rom_q for the previous hit arrives now, while the new pixel misses.
        pix(10'd132, 10'd50, 1'b1, 8'd5, 12'hF81);
        #1;
        n_checks++;
        if (addr_a !== 13'd2048) begin
            n_fail++; $display("FAIL basic_addr_nohit_base: got %0d want 2048", addr_a);
        end
        tick();
        n_checks++;
        if ({opaque_a, red_a, green_a, blue_a} !== 13'h1F81) begin
            n_fail++; $display("FAIL basic_output_L2: got %h want 1f81", {opaque_a, red_a, green_a, blue_a});
        end
        tick();
        n_checks++;
        if ({opaque_a, red_a, green_a, blue_a} !== 13'h0) begin
            n_fail++; $display("FAIL basic_output_after: got %h want 0", {opaque_a, red_a, green_a, blue_a});
        end
        pix(10'd131, 10'd81, 1'b1, 8'd0, 12'h000);
        #1;
        n_checks++;
        if (addr_a !== 13'd3071) begin
            n_fail++; $display("FAIL basic_addr_far_corner: got %0d want 3071", addr_a);
        end
        hold(10'd132, 10'd81, 8'd5, 12'hF81);
        n_checks++;
        if (opaque_a !== 1'b0) begin
            n_fail++; $display("FAIL basic_right_edge_nohit: got %b want 0", opaque_a);
        end
    endtask

    task automatic test_async_reset();
        load_shadow(10'd100, 10'd50, 3'd2, 1'b0, 1'b0, 1'b1);
        hold(10'd110, 10'd60, 8'd5, 12'hF81);
        n_checks++;
        if (opaque_a !== 1'b1) begin
            n_fail++; $display("FAIL areset_prior_opaque: got %b want 1", opaque_a);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({opaque_a, red_a, green_a, blue_a} !== 13'h0) begin
            n_fail++; $display("FAIL areset_immediate: got %h want 0", {opaque_a, red_a, green_a, blue_a});
        end
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (opaque_a !== 1'b0) begin
            n_fail++; $display("FAIL areset_shadow_cleared: got %b want 0", opaque_a);
        end
    endtask

    task automatic test_transparency_blank();
        load_shadow(10'd100, 10'd50, 3'd2, 1'b0, 1'b0, 1'b1);
        hold(10'd110, 10'd60, 8'd0, 12'hFFF);
        n_checks++;
        if ({opaque_a, red_a, green_a, blue_a} !== 13'h0) begin
            n_fail++; $display("FAIL transparent_idx: got %h want 0", {opaque_a, red_a, green_a, blue_a});
        end
        pix(10'd110, 10'd60, 1'b0, 8'd5, 12'hFFF);
        repeat (3) tick();
        n_checks++;
        if ({opaque_a, red_a, green_a, blue_a} !== 13'h0) begin
            n_fail++; $display("FAIL blank_inside: got %h want 0", {opaque_a, red_a, green_a, blue_a});
        end
        hold(10'd110, 10'd60, 8'd7, 12'h3C5);
        n_checks++;
        if ({opaque_a, red_a, green_a, blue_a} !== 13'h13C5) begin
            n_fail++; $display("FAIL visible_inside: got %h want 13c5", {opaque_a, red_a, green_a, blue_a});
        end
    endtask

    task automatic test_mirror();
        load_shadow(10'd0, 10'd0, 3'd0, 1'b1, 1'b1, 1'b1);
        pix(10'd0, 10'd0, 1'b1, 8'd0, 12'h000);
        #1;
        n_checks++;
        if (addr_a !== 13'd1023) begin
            n_fail++; $display("FAIL mirror_xy_origin: got %0d want 1023", addr_a);
        end
        pix(10'd31, 10'd31, 1'b1, 8'd0, 12'h000);
        #1;
        n_checks++;
        if (addr_a !== 13'd0) begin
            n_fail++; $display("FAIL mirror_xy_far: got %0d want 0", addr_a);
        end
        pix(10'd5, 10'd2, 1'b1, 8'd0, 12'h000);
        #1;
        n_checks++;
        if (addr_a !== 13'd954) begin
            n_fail++; $display("FAIL mirror_xy_mid: got %0d want 954", addr_a);
        end
        load_shadow(10'd0, 10'd0, 3'd0, 1'b1, 1'b0, 1'b1);
        pix(10'd5, 10'd2, 1'b1, 8'd0, 12'h000);
        #1;
        n_checks++;
        if (addr_a !== 13'd90) begin
            n_fail++; $display("FAIL mirror_x_only: got %0d want 90", addr_a);
        end
    endtask

    task automatic test_scale_clip();
        load_shadow(10'd620, 10'd470, 3'd0, 1'b0, 1'b0, 1'b1);
        pix(10'd621, 10'd471, 1'b1, 8'd0, 12'h000);
        #1;
        n_checks++;
        if (addr_b !== 13'd0) begin
            n_fail++; $display("FAIL scale_first_texel: got %0d want 0", addr_b);
        end
        pix(10'd639, 10'd471, 1'b1, 8'd0, 12'h000);
        #1;
        n_checks++;
        if (addr_b !== 13'd9) begin
            n_fail++; $display("FAIL scale_lx9: got %0d want 9", addr_b);
        end
        pix(10'd639, 10'd479, 1'b1, 8'd0, 12'h000);
        #1;
        n_checks++;
        if (addr_b !== 13'd137) begin
            n_fail++; $display("FAIL scale_bottom_right: got %0d want 137", addr_b);
        end
        hold(10'd620, 10'd470, 8'd5, 12'hF81);
        n_checks++;
        if ({opaque_b, red_b, green_b, blue_b} !== 13'h1F81) begin
            n_fail++; $display("FAIL scale_hit_opaque: got %h want 1f81", {opaque_b, red_b, green_b, blue_b});
        end
        hold(10'd0, 10'd472, 8'd5, 12'hF81);
        n_checks++;
        if (opaque_b !== 1'b0) begin
            n_fail++; $display("FAIL clip_no_wrap: got %b want 0", opaque_b);
        end
        load_shadow(10'd200, 10'd100, 3'd0, 1'b0, 1'b0, 1'b1);
        pix(10'd263, 10'd163, 1'b1, 8'd0, 12'h000);
        #1;
        n_checks++;
        if (addr_b !== 13'd1023) begin
            n_fail++; $display("FAIL scale_span_last: got %0d want 1023", addr_b);
        end
        hold(10'd263, 10'd100, 8'd5, 12'hF81);
        n_checks++;
        if (opaque_b !== 1'b1) begin
            n_fail++; $display("FAIL scale_span_63: got %b want 1", opaque_b);
        end
        hold(10'd264, 10'd100, 8'd5, 12'hF81);
        n_checks++;
        if (opaque_b !== 1'b0) begin
            n_fail++; $display("FAIL scale_span_64: got %b want 0", opaque_b);
        end
    endtask

    task automatic test_shadow_clamp();
        load_shadow(10'd300, 10'd200, 3'd0, 1'b0, 1'b0, 1'b1);
        pos_x = 10'd400; pos_y = 10'd300;
        hold(10'd300, 10'd200, 8'd5, 12'hF81);
        n_checks++;
        if (opaque_a !== 1'b1) begin
            n_fail++; $display("FAIL shadow_old_pos_kept: got %b want 1", opaque_a);
        end
        hold(10'd400, 10'd300, 8'd5, 12'hF81);
        n_checks++;
        if (opaque_a !== 1'b0) begin
            n_fail++; $display("FAIL shadow_new_pos_early: got %b want 0", opaque_a);
        end
        load_shadow(10'd400, 10'd300, 3'd0, 1'b0, 1'b0, 1'b1);
        hold(10'd400, 10'd300, 8'd5, 12'hF81);
        n_checks++;
        if (opaque_a !== 1'b1) begin
            n_fail++; $display("FAIL shadow_new_pos_loaded: got %b want 1", opaque_a);
        end
        hold(10'd300, 10'd200, 8'd5, 12'hF81);
        n_checks++;
        if (opaque_a !== 1'b0) begin
            n_fail++; $display("FAIL shadow_old_pos_gone: got %b want 0", opaque_a);
        end
        load_shadow(10'd0, 10'd0, 3'd7, 1'b0, 1'b0, 1'b1);
        pix(10'd600, 10'd400, 1'b1, 8'd0, 12'h000);
        #1;
        n_checks++;
        if (addr_a !== 13'd7168) begin
            n_fail++; $display("FAIL frame7_base: got %0d want 7168", addr_a);
        end
        n_checks++;
        if (addr_b !== 13'd5120) begin
            n_fail++; $display("FAIL clamp_7_to_5: got %0d want 5120", addr_b);
        end
        load_shadow(10'd0, 10'd0, 3'd6, 1'b0, 1'b0, 1'b1);
        pix(10'd600, 10'd400, 1'b1, 8'd0, 12'h000);
        #1;
        n_checks++;
        if (addr_b !== 13'd5120) begin
            n_fail++; $display("FAIL clamp_6_to_5: got %0d want 5120", addr_b);
        end
        load_shadow(10'd0, 10'd0, 3'd4, 1'b0, 1'b0, 1'b1);
        pix(10'd600, 10'd400, 1'b1, 8'd0, 12'h000);
        #1;
        n_checks++;
        if (addr_b !== 13'd4096) begin
            n_fail++; $display("FAIL clamp_4_passes: got %0d want 4096", addr_b);
        end
    endtask

    task automatic test_frame_start_coincide();
        load_shadow(10'd400, 10'd300, 3'd1, 1'b0, 1'b0, 1'b1);
        pos_x = 10'd500; frame_sel = 3'd3;
        pix(10'd401, 10'd300, 1'b1, 8'd0, 12'h000);
        frame_start = 1'b1;
        #1;
        n_checks++;
        if (addr_a !== 13'd1025) begin
            n_fail++; $display("FAIL fs_pixel_uses_old: got %0d want 1025", addr_a);
        end
        tick();
        frame_start = 1'b0;
        #1;
        n_checks++;
        if (addr_a !== 13'd3072) begin
            n_fail++; $display("FAIL fs_next_uses_new: got %0d want 3072", addr_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_async_reset();
        test_transparency_blank();
        test_mirror();
        test_scale_clip();
        test_shadow_clamp();
        test_frame_start_coincide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
